// File: rtl/parc_corereorderbuffer.sv
// 16-entry in-order reorder buffer. Slots are allocated at decode and filled at
// writeback. Results feed decode through two bypass ports and retire in order.
module parc_corereorderbuffer #(
  parameter int p_num_entries = 16,
  parameter int p_data_nbits  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rob_alloc_req_val,
  output logic                    rob_alloc_req_rdy,
  input  logic [4:0]              rob_alloc_req_preg,
  output logic [3:0]              rob_alloc_resp_slot,
  input  logic                    rob_fill_val,
  input  logic [3:0]              rob_fill_slot,
  input  logic [p_data_nbits-1:0] rob_fill_data,
  input  logic                    rob_kill_val,
  input  logic [3:0]              rob_byp0_slot,
  output logic [p_data_nbits-1:0] rob_byp0_data,
  output logic                    rob_byp0_val,
  input  logic [3:0]              rob_byp1_slot,
  output logic [p_data_nbits-1:0] rob_byp1_data,
  output logic                    rob_byp1_val,
  output logic                    rob_commit_wen,
  output logic [3:0]              rob_commit_slot,
  output logic [4:0]              rob_commit_rf_waddr,
  output logic [p_data_nbits-1:0] rob_commit_data
);

  logic [p_num_entries-1:0] valid_q;
  logic [p_num_entries-1:0] pending_q;
  logic [4:0]               preg_q [p_num_entries];
  logic [p_data_nbits-1:0]  data_q [p_num_entries];
  logic [3:0]               head_q;
  logic [3:0]               tail_q;
  logic [4:0]               count_q;

  logic [3:0] tail_m1;
  logic       alloc_fire;
  logic       commit_fire;
  logic       kill_fire;
  logic       fill_fire;

  assign tail_m1   = tail_q - 4'd1;
  assign kill_fire = rob_kill_val && (count_q != 5'd0);

  // Kill owns the tail this cycle, so allocation is held off while it is raised.
  assign rob_alloc_req_rdy   = (count_q != 5'(p_num_entries)) && !rob_kill_val;
  assign rob_alloc_resp_slot = tail_q;
  assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;

  // A lone entry that is being squashed must not also retire.
  assign commit_fire = valid_q[head_q] && !pending_q[head_q]
                       && !(kill_fire && (count_q == 5'd1));

  assign fill_fire = rob_fill_val && valid_q[rob_fill_slot]
                     && !(alloc_fire && (rob_fill_slot == tail_q));

  always_comb begin
    rob_commit_wen      = commit_fire;
    rob_commit_slot     = head_q;
    rob_commit_rf_waddr = 5'd0;
    rob_commit_data     = '0;
    if (commit_fire) begin
      rob_commit_rf_waddr = preg_q[head_q];
      rob_commit_data     = data_q[head_q];
    end
  end

  always_comb begin
    rob_byp0_val  = valid_q[rob_byp0_slot] && !pending_q[rob_byp0_slot];
    rob_byp1_val  = valid_q[rob_byp1_slot] && !pending_q[rob_byp1_slot];
    rob_byp0_data = rob_byp0_val ? data_q[rob_byp0_slot] : '0;
    rob_byp1_data = rob_byp1_val ? data_q[rob_byp1_slot] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      pending_q <= '0;
      head_q    <= 4'd0;
      tail_q    <= 4'd0;
      count_q   <= 5'd0;
    end else begin
      if (fill_fire) pending_q[rob_fill_slot] <= 1'b0;
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 4'd1;
      end
      if (kill_fire) begin
        valid_q[tail_m1] <= 1'b0;
        tail_q           <= tail_m1;
      end
      if (alloc_fire) begin
        valid_q[tail_q]   <= 1'b1;
        pending_q[tail_q] <= 1'b1;
        tail_q            <= tail_q + 4'd1;
      end
      count_q <= count_q + 5'(alloc_fire) - 5'(commit_fire) - 5'(kill_fire);
    end
  end

  // Payload arrays carry no reset; valid/pending gate every read of them.
  always_ff @(posedge clk) begin
    if (!reset && fill_fire) data_q[rob_fill_slot] <= rob_fill_data;
    if (!reset && alloc_fire) preg_q[tail_q] <= rob_alloc_req_preg;
  end

endmodule
